pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//   Parametrised successor to the fixed-field inter-stage pipeline registers.
//   Carries a WIDTH-bit packed payload between two pipeline stages with
//   valid/ready handshake, a 2-entry skid buffer and synchronous flush.
//   Registered in_ready breaks the combinational stall path between stages.
//   Full throughput (1 beat/cycle) at 1-cycle latency.
// PARAMETERS
//   WIDTH      32   payload width in bits (packed stage fields), >=1
//   CLEAR_VAL  0    WIDTH-bit value driven on out_data when stage holds no beat
//   CNT_W      16   width of statistics counters, >=2
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-high reset
//   flush        in   1      sync clear: discard all held beats (mispredict/exception)
//   in_valid     in   1      upstream beat present
//   in_ready     out  1      stage can accept a beat (registered)
//   in_data      in   WIDTH  upstream payload
//   out_valid    out  1      beat present on out_data
//   out_ready    in   1      downstream accepts beat this cycle
//   out_data     out  WIDTH  payload of oldest held beat
//   occupancy    out  2      held beats: 0,1,2
//   stats_clr    in   1      sync clear of statistics counters
//   stall_cnt    out  CNT_W  cycles with out_valid & !out_ready (saturating)
//   flush_cnt    out  CNT_W  flushes that discarded >=1 beat (saturating)
// BEHAVIOUR
//   - Storage: main reg (drives out_data) + skid reg. States EMPTY, ONE, TWO.
//   - Reset (rst=1, async): state EMPTY; out_valid=0; in_ready=1;
//     out_data=CLEAR_VAL; skid=CLEAR_VAL; occupancy=0; stall_cnt=flush_cnt=0.
//   - in_ready = (state != TWO), registered; in beat accepted iff in_valid&in_ready.
//   - Transitions (no flush), acc = in_valid&in_ready, drn = out_valid&out_ready:
//     EMPTY: acc -> ONE, main<=in_data.  else stay.
//     ONE:   acc&drn -> ONE, main<=in_data;  acc&!drn -> TWO, skid<=in_data;
//            !acc&drn -> EMPTY, main<=CLEAR_VAL;  else stay.
//     TWO:   drn -> ONE, main<=skid, skid<=CLEAR_VAL; else stay (no accept).
//   - Order preserved: beats leave in acceptance order; no beat lost/duplicated.
//   - flush=1 (highest priority after rst): next state EMPTY, main,skid<=CLEAR_VAL,
//     in_ready<=1; an in beat offered that cycle is dropped; a drn that cycle
//     still counts as delivered downstream (downstream owns its flush).
//   - out_data == CLEAR_VAL whenever out_valid=0 (bubble is all-CLEAR_VAL).
//   - out_valid=1 and out_data held stable while !out_ready (no retraction).
//   - occupancy = 0/1/2 for EMPTY/ONE/TWO, registered with state.
//   - Counters saturate at 2^CNT_W-1, no wrap; stats_clr zeroes both next cycle,
//     overriding an increment in the same cycle.
//   - Reset mid-transfer: all held beats lost, outputs to reset values at once.
// CONFIGURATION
//   PIPE_STAGE_STATS_EN defined: stall_cnt/flush_cnt implemented as above.
//   Undefined: counter logic removed; stall_cnt, flush_cnt tied to 0; stats_clr
//   ignored. Port list identical in both builds.
// TESTING
//   1 Reset: rst=1 -> out_valid=0,in_ready=1,out_data=CLEAR_VAL,occupancy=0.
//   2 Streaming: out_ready=1, in beats 0x11,0x22,0x33 back-to-back -> out_data
//     0x11,0x22,0x33 on cycles 1,2,3 after accept, occupancy stays 1.
//   3 Stall/skid: out_ready=0 while 0xA1,0xA2 accepted -> occupancy=2,
//     in_ready=0, out_data=0xA1 held; out_ready=1 -> 0xA1 then 0xA2, in_ready=1.
//   4 Flush in TWO with in_valid=1 (0xB0) -> next cycle EMPTY, out_valid=0,
//     out_data=CLEAR_VAL, 0xB0 never appears; flush_cnt=1 (STATS_EN).
//   5 Stats: out_valid=1,out_ready=0 for 5 cycles -> stall_cnt=5; CNT_W=2,
//     6 stall cycles -> stall_cnt=3; stats_clr -> 0. Without macro: counters 0.
//   6 Random valid/ready scoreboard, 10k cycles: output sequence == input
//     sequence minus flushed beats; out_data stable whenever out_valid&!out_ready.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry skid buffer, synchronous flush
// and optional statistics counters (enabled by defining PIPE_STAGE_STATS_EN).
module pipe_stage_skid #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [1:0]       occupancy_q, occupancy_d;
    logic             acc, drn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= CLEAR_VAL;
            skid_q      <= CLEAR_VAL;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    // Flush wins over any handshake; a beat offered during flush is dropped.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = CLEAR_VAL;
            skid_d  = CLEAR_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        main_d = in_data;
                    end else if (acc) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (drn) begin
                        state_d = EMPTY;
                        main_d  = CLEAR_VAL;
                    end
                end
                TWO: begin
                    if (drn) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = CLEAR_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = CLEAR_VAL;
                    skid_d  = CLEAR_VAL;
                end
            endcase
        end
        in_ready_d  = (state_d != TWO);
        occupancy_d = 2'(state_d);
    end

    // main_q is cleared on every path to EMPTY, so it is already the bubble value.
    always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = main_q;
        in_ready  = in_ready_q;
        occupancy = occupancy_q;
        acc       = in_valid && in_ready_q;
        drn       = out_valid && out_ready;
    end

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Saturating counters; a clear request overrides any increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stats_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt_q != CNT_MAX)
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (flush && state_q != EMPTY && flush_cnt_q != CNT_MAX)
                flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign stall_cnt        = '0;
    assign flush_cnt        = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed vector table, counter and reset
// sequences, then a randomised scoreboard run.
module tb_pipe_stage_skid;

    localparam int          W   = 16;
    localparam logic [15:0] CLR = 16'hDEAD;
`ifdef PIPE_STAGE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          out_ready = 1'b0;
    logic          stats_clr = 1'b0;
    logic          in_ready, out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt, flush_cnt;
    logic          in_ready2, out_valid2;
    logic [W-1:0]  out_data2;
    logic [1:0]    occupancy2;
    logic [1:0]    stall_cnt2, flush_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(W), .CLEAR_VAL(CLR), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stats_clr(stats_clr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_skid #(.WIDTH(W), .CLEAR_VAL(CLR), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occupancy(occupancy2), .stats_clr(stats_clr),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        fl;
        logic        eov;
        logic [15:0] eod;
        logic [1:0]  eocc;
        logic        eir;
    } vec_t;

    vec_t vecs[16];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [15:0] d, input logic ordy,
                                 input logic fl, input logic clr);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        stats_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_exp(input int v);
        return STATS_ON ? 32'(v) : 32'd0;
    endfunction

    function automatic logic [31:0] cnt_exp_small(input int v);
        return STATS_ON ? ((v > 3) ? 32'd3 : 32'(v)) : 32'd0;
    endfunction

    initial begin
        int          exp_stall;
        int          exp_flush;
        logic        prev_ov;
        logic [1:0]  prev_occ;
        logic [15:0] q[$];
        logic        hold;
        logic [15:0] hold_data;
        logic        rv, rr, rf;
        logic [15:0] rd;

        vecs[0]  = '{1'b1, 16'h0011, 1'b1, 1'b0, 1'b1, 16'h0011, 2'd1, 1'b1};
        vecs[1]  = '{1'b1, 16'h0022, 1'b1, 1'b0, 1'b1, 16'h0022, 2'd1, 1'b1};
        vecs[2]  = '{1'b1, 16'h0033, 1'b1, 1'b0, 1'b1, 16'h0033, 2'd1, 1'b1};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, CLR,      2'd0, 1'b1};
        vecs[4]  = '{1'b1, 16'h00A1, 1'b0, 1'b0, 1'b1, 16'h00A1, 2'd1, 1'b1};
        vecs[5]  = '{1'b1, 16'h00A2, 1'b0, 1'b0, 1'b1, 16'h00A1, 2'd2, 1'b0};
        vecs[6]  = '{1'b1, 16'h00A3, 1'b0, 1'b0, 1'b1, 16'h00A1, 2'd2, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h00A2, 2'd1, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, CLR,      2'd0, 1'b1};
        vecs[9]  = '{1'b1, 16'h00C1, 1'b0, 1'b0, 1'b1, 16'h00C1, 2'd1, 1'b1};
        vecs[10] = '{1'b1, 16'h00C2, 1'b0, 1'b0, 1'b1, 16'h00C1, 2'd2, 1'b0};
        vecs[11] = '{1'b1, 16'h00B0, 1'b0, 1'b1, 1'b0, CLR,      2'd0, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, CLR,      2'd0, 1'b1};
        vecs[13] = '{1'b1, 16'h00D1, 1'b0, 1'b0, 1'b1, 16'h00D1, 2'd1, 1'b1};
        vecs[14] = '{1'b1, 16'h00D2, 1'b1, 1'b0, 1'b1, 16'h00D2, 2'd1, 1'b1};
        vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, CLR,      2'd0, 1'b1};

        // Reset values while reset is held.
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_out_data",  32'(out_data),  32'(CLR));
        checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Directed table: streaming, skid stall, flush in TWO, flush in EMPTY.
        exp_stall = 0;
        exp_flush = 0;
        prev_ov   = 1'b0;
        prev_occ  = 2'd0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, 1'b0);
            if (prev_ov && !vecs[i].ordy) exp_stall++;
            if (vecs[i].fl && prev_occ != 2'd0) exp_flush++;
            tick();
            checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
            checkOutput($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(vecs[i].eod));
            checkOutput($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].eocc));
            checkOutput($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].eir));
            checkOutput($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), cnt_exp(exp_stall));
            checkOutput($sformatf("vec%0d_flush_cnt", i), 32'(flush_cnt), cnt_exp(exp_flush));
            checkOutput($sformatf("vec%0d_stall_cnt2", i), 32'(stall_cnt2), cnt_exp_small(exp_stall));
            prev_ov  = vecs[i].eov;
            prev_occ = vecs[i].eocc;
        end

        // Counter clear, stall counting and saturation of the 2-bit instance.
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("clr_stall_cnt",  32'(stall_cnt),  32'd0);
        checkOutput("clr_flush_cnt",  32'(flush_cnt),  32'd0);
        checkOutput("clr_stall_cnt2", 32'(stall_cnt2), 32'd0);
        applyStimulus(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 6; n++) begin
            tick();
            checkOutput($sformatf("stall%0d_cnt", n),  32'(stall_cnt),  cnt_exp(n));
            checkOutput($sformatf("stall%0d_cnt2", n), 32'(stall_cnt2), cnt_exp_small(n));
            checkOutput($sformatf("stall%0d_data", n), 32'(out_data),   32'h0055);
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("clr_over_inc_cnt",  32'(stall_cnt),  32'd0);
        checkOutput("clr_over_inc_cnt2", 32'(stall_cnt2), 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("drain_out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset while holding two beats.
        applyStimulus(1'b1, 16'h00E1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h00E2, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("pre_rst_occupancy", 32'(occupancy), 32'd2);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("mid_rst_out_data",  32'(out_data),  32'(CLR));
        checkOutput("mid_rst_occupancy", 32'(occupancy), 32'd0);
        checkOutput("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Random traffic against a queue scoreboard.
        q.delete();
        hold = 1'b0;
        hold_data = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rv = ($urandom_range(99) < 70);
            rr = ($urandom_range(99) < 60);
            rf = ($urandom_range(99) < 3);
            rd = 16'($urandom);
            applyStimulus(rv, rd, rr, rf, 1'b0);
            if (out_valid && rr) begin
                if (q.size() == 0) begin
                    checkOutput("sb_unexpected_beat", 32'(out_data), 32'(CLR));
                end else begin
                    checkOutput("sb_data", 32'(out_data), 32'(q[0]));
                    void'(q.pop_front());
                end
            end
            if (rf) q.delete();
            else if (rv && in_ready) q.push_back(rd);
            hold      = out_valid && !rr && !rf;
            hold_data = out_data;
            tick();
            checkOutput("sb_occupancy", 32'(occupancy), 32'(q.size()));
            checkOutput("sb_out_valid", 32'(out_valid), 32'(q.size() != 0));
            checkOutput("sb_in_ready",  32'(in_ready),  32'(q.size() < 2));
            if (!out_valid) checkOutput("sb_bubble_data", 32'(out_data), 32'(CLR));
            if (hold) checkOutput("sb_hold_data", 32'(out_data), 32'(hold_data));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
